// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Measures the period and high time of a slow asynchronous square
//            wave in clk cycles, with a stalled-input timeout.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             valid_o,
  output logic             stalled_o
);

  // Timeout threshold at counter width; TIMEOUT < 2^CNT_W keeps it exact.
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  state_t           state_q;
  logic             s1_q;
  logic             s2_q;
  logic             s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             valid_q;
  logic             stalled_q;

  logic             rise_d;
  logic             timeout_d;
  logic [CNT_W-1:0] cnt_inc_d;
  logic [CNT_W-1:0] hcnt_inc_d;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge detect, timeout compare and counter increments.
  always_comb begin
    rise_d     = s2_q & ~s3_q;
    timeout_d  = (cnt_q == C_TIMEOUT);
    cnt_inc_d  = cnt_q + C_ONE;
    hcnt_inc_d = hcnt_q + CNT_W'(s2_q);
  end

  // Measurement FSM: counts between rises, reports on rise, gives up at timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      stalled_q   <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // First edge only opens a period; nothing complete to report yet.
          if (rise_d) begin
            cnt_q   <= C_ONE;
            hcnt_q  <= C_ONE;
            state_q <= S_MEAS;
          end
        end
        S_MEAS: begin
          // A rise takes priority over a timeout landing in the same cycle.
          if (rise_d) begin
            period_q    <= cnt_q;
            high_time_q <= hcnt_q;
            valid_q     <= 1'b1;
            stalled_q   <= 1'b0;
            cnt_q       <= C_ONE;
            hcnt_q      <= C_ONE;
          end else if (timeout_d) begin
            period_q    <= '0;
            high_time_q <= '0;
            stalled_q   <= 1'b1;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            state_q     <= S_IDLE;
          end else begin
            cnt_q  <= cnt_inc_d;
            hcnt_q <= hcnt_inc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign period_o    = period_q;
  assign high_time_o = high_time_q;
  assign valid_o     = valid_q;
  assign stalled_o   = stalled_q;

endmodule
`default_nettype wire

// File: doc/freq_meter.md
# freq_meter

Measures the period and high time of a slow, asynchronous square-wave input (typically the output of the counter-path clock divider) in system clock cycles. It is the consumer of that divided clock: the divider produces the slow clock, and this block checks it in hardware. Results drive the display/debug logic and the self-check benches of the counter project. It includes an input synchronizer, a two-state measurement FSM and timeout detection for a stalled input.

## Interface
- CNT_W, 32, width of the period and high-time counters and outputs.
- TIMEOUT, 50000000, clk cycles without a rising edge before the input is declared stalled.
  - Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- sig_in  input  1  measured signal, asynchronous to clk.
- period  output  CNT_W  clk cycles between the last two detected rising edges of sig_in.
- high_time  output  CNT_W  clk cycles the synchronized sig_in was high within that period.
- valid  output  1  one-cycle pulse; period and high_time were updated this cycle.
- stalled  output  1  level; no rising edge seen for TIMEOUT cycles, or none since reset.

## Operation
- Synchronizer: two flip-flops take sig_in to s2. A third register holds s3, the previous value of s2.
  - Rising edge detect: rise = s2 & ~s3.
  - All synchronizer flops reset to 0.
- Counters:
  - cnt counts clk cycles since the last rise.
  - hcnt counts the cycles in the current period where s2 = 1.
- FSM state IDLE (reset state):
  - Waits for rise. On rise: cnt←1, hcnt←s2 (=1), go to MEAS.
  - valid stays 0 on this first edge, because no complete period exists yet.
- FSM state MEAS:
  - Each cycle without rise: cnt←cnt+1, hcnt←hcnt+s2.
  - On rise: period←cnt, high_time←hcnt, valid←1, stalled←0, cnt←1, hcnt←1.
  - On reaching cnt = TIMEOUT without rise: stalled←1, period←0, high_time←0, go to IDLE with no valid pulse.
- Simultaneous events:
  - If rise and cnt = TIMEOUT occur in the same cycle, rise wins and the measurement is reported.
  - rst has priority over everything.
- No counter ever wraps. TIMEOUT bounds cnt below 2^CNT_W.
- A constant-high or constant-low input never produces valid. stalled stays 1.
- Reset values:
  - period = 0, high_time = 0, valid = 0, stalled = 1.
  - State IDLE, cnt = 0, hcnt = 0.
- Reset mid-measurement discards the partial period. The next measurement needs two fresh rising edges after rst is released.

## Timing
- sig_in rise to internal rise: 2–3 clk cycles, depending on the sampling phase of the synchronizer.
- rise to outputs: valid, period and high_time are registered and appear 1 cycle after the rise cycle.
  - valid is high for exactly 1 cycle.
- Outputs hold between valid pulses.
- Minimum measurable period is 2 cycles. Minimum high or low phase is 1 cycle. Shorter pulses may be missed by the synchronizer, and that is acceptable.
- stalled asserts 1 cycle after the cycle in which cnt = TIMEOUT.
- stalled deasserts together with the first valid pulse after it was set.
- Throughput is one measurement per input period. There is no backpressure.

## Test plan
- Reset behaviour:
  - Stimulus: rst high for 2 cycles, sig_in = 0, TIMEOUT = 100.
  - Required: period = 0, high_time = 0, valid = 0 and stalled = 1 during reset and for all following cycles while sig_in stays 0.
- 50 % duty:
  - Stimulus: sig_in toggles every 5 clk cycles (10 ns clk).
  - Required: the first valid arrives 1 cycle after the second detected rise, with period = 10, high_time = 5 and stalled going to 0.
  - Required: valid then repeats every 10 cycles with the same values.
- Asymmetric duty:
  - Stimulus: sig_in 3 cycles high, 7 cycles low.
  - Required: period = 10, high_time = 3 on every valid.
  - Stimulus: switch to 8 high / 4 low.
  - Required: within two periods, period = 12, high_time = 8.
- Timeout:
  - Stimulus: TIMEOUT = 100, toggle sig_in for several periods, then hold sig_in low.
  - Required: stalled = 1 exactly 101 cycles after the last detected rise, with period = 0, high_time = 0 and no valid.
  - Stimulus: restart toggling.
  - Required: first valid after the second rise, at which point stalled returns to 0.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle halfway through a 10-cycle period.
  - Required: all outputs return to reset values.
  - Required: the next valid follows the second rise after reset and reports period = 10.
- Divider loopback:
  - Stimulus: drive sig_in from the divider output, configured to toggle every N clk cycles.
  - Required: period = 2N and high_time = N on every valid.
